axis_i2c_byte_master: RTL and testbench

- AXI-Stream to I2C single-byte master.
- Each accepted s_axis word is one I2C transaction: START, address+R/W, one data byte written or read, STOP.
- Read bytes are returned on an m_axis port.
- Sits behind a clock-domain-crossing AXIS FIFO; clocked by the divided I2C base clock (200 kHz typical, giving 50 kHz SCL).

---
 rtl/axis_i2c_byte_master.sv | 162 ++++++++++++++++
 tb/tb_axis_i2c_byte_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_i2c_byte_master.sv
// Purpose: AXI-Stream command word -> one I2C transaction (START, addr+R/W, one data byte, STOP); read byte returned on m_axis.
// Latency: 80 clk_i cycles from s_axis handshake back to IDLE (44 on address NACK); read data valid 76 cycles after handshake.
// Backpressure: s_axis_tready only in IDLE with no read byte pending; m_axis_tvalid holds data until the tready handshake.
module axis_i2c_byte_master #(
    parameter int I2C_DATA_WIDTH  = 8,
    parameter int AXIS_DATA_WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       arstn_i,
    output logic                       i2c_scl_o,
    inout  wire                        i2c_sda_io,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [I2C_DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_NACK,
        ST_STOP
    } state_e;

    state_e                      state_q, state_d;
    logic [1:0]                  phase_q, phase_d;
    logic [2:0]                  bit_q, bit_d;
    logic [AXIS_DATA_WIDTH-1:0]  cmd_q;
    logic                        sda_smp_q;
    logic [I2C_DATA_WIDTH-1:0]   rx_q;
    logic [I2C_DATA_WIDTH-1:0]   m_tdata_q;
    logic                        m_tvalid_q;
    logic [1:0]                  rst_sync_q;
    logic                        rst_n;
    logic                        scl_c;
    logic                        sda_rel_c;
    logic                        sda_in;
    logic                        s_hs;
    logic [7:0]                  tx_byte;
    logic                        tx_bit;

    // Open-drain SDA: only ever pull low, otherwise release and read the bus.
    assign i2c_sda_io = sda_rel_c ? 1'bz : 1'b0;
    assign sda_in     = i2c_sda_io;
    assign i2c_scl_o  = scl_c;

    assign rst_n         = rst_sync_q[1];
    assign s_axis_tready = rst_n && (state_q == ST_IDLE) && !m_tvalid_q;
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;

    // Address byte is {addr[6:0], rw} = cmd[15:8]; data byte is cmd[7:0].
    assign tx_byte = (state_q == ST_ADDR) ? cmd_q[15:8] : cmd_q[7:0];
    assign tx_bit  = tx_byte[3'd7 - bit_q];

    // Reset synchronizer: assertion is immediate, release aligns to clk_i.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    // State register with phase and bit counters.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= 2'd0;
            bit_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
        end
    end

    // Next-state: every state lasts whole 4-cycle phases; transitions happen at q3.
    always_comb begin
        state_d = state_q;
        phase_d = (state_q == ST_IDLE) ? 2'd0 : phase_q + 2'd1;
        bit_d   = 3'd0;
        if (state_q == ST_ADDR || state_q == ST_WR_DATA || state_q == ST_RD_DATA)
            bit_d = (phase_q == 2'd3) ? bit_q + 3'd1 : bit_q;
        unique case (state_q)
            ST_IDLE:     if (s_hs) state_d = ST_START;
            ST_START:    if (phase_q == 2'd3) state_d = ST_ADDR;
            ST_ADDR:     if (phase_q == 2'd3 && bit_q == 3'd7) state_d = ST_ADDR_ACK;
            ST_ADDR_ACK: if (phase_q == 2'd3) begin
                             if (sda_smp_q)     state_d = ST_STOP;
                             else if (cmd_q[8]) state_d = ST_RD_DATA;
                             else               state_d = ST_WR_DATA;
                         end
            ST_WR_DATA:  if (phase_q == 2'd3 && bit_q == 3'd7) state_d = ST_WR_ACK;
            ST_WR_ACK:   if (phase_q == 2'd3) state_d = ST_STOP;
            ST_RD_DATA:  if (phase_q == 2'd3 && bit_q == 3'd7) state_d = ST_RD_NACK;
            ST_RD_NACK:  if (phase_q == 2'd3) state_d = ST_STOP;
            ST_STOP:     if (phase_q == 2'd3) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Bus outputs decoded from state and phase.
    always_comb begin
        scl_c     = 1'b1;
        sda_rel_c = 1'b1;
        unique case (state_q)
            ST_START: begin
                scl_c     = (phase_q != 2'd3);
                sda_rel_c = (phase_q == 2'd0);
            end
            ST_ADDR, ST_WR_DATA: begin
                scl_c     = (phase_q == 2'd1) || (phase_q == 2'd2);
                sda_rel_c = tx_bit;
            end
            ST_ADDR_ACK, ST_WR_ACK, ST_RD_DATA, ST_RD_NACK: begin
                scl_c     = (phase_q == 2'd1) || (phase_q == 2'd2);
                sda_rel_c = 1'b1;
            end
            ST_STOP: begin
                scl_c     = (phase_q != 2'd0);
                sda_rel_c = (phase_q[1] == 1'b1);
            end
            default: begin
                scl_c     = 1'b1;
                sda_rel_c = 1'b1;
            end
        endcase
    end

    // Datapath: command latch, SDA sampling, read shift register and m_axis holding register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q      <= '0;
            sda_smp_q  <= 1'b0;
            rx_q       <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
        end else begin
            if (s_hs)
                cmd_q <= s_axis_tdata;
            if (phase_q == 2'd2)
                sda_smp_q <= sda_in;
            if (state_q == ST_RD_DATA && phase_q == 2'd2)
                rx_q <= {rx_q[I2C_DATA_WIDTH-2:0], sda_in};
            // A new byte can only arrive after the previous one was popped,
            // because commands are blocked while tvalid is high.
            if (state_q == ST_RD_NACK && phase_q == 2'd3) begin
                m_tdata_q  <= rx_q;
                m_tvalid_q <= 1'b1;
            end else if (m_tvalid_q && m_axis_tready) begin
                m_tvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_i2c_byte_master.sv
// Purpose: directed bench for axis_i2c_byte_master with a reactive I2C slave model on the bus.
// Latency: checks 80-cycle write/read transactions, 76-cycle read-data valid, 44-cycle address NACK.
// Backpressure: exercises m_axis stall with a pending s_axis command and held s_axis_tvalid back-to-back.
module tb_axis_i2c_byte_master;

    logic        clk = 1'b0;
    logic        arstn;
    logic [15:0] s_tdata;
    logic        s_tvalid;
    wire         s_tready;
    wire  [7:0]  m_tdata;
    wire         m_tvalid;
    logic        m_tready;
    wire         scl;
    wire         sda_bus;
    logic        slv_low;

    always #5 clk = ~clk;

    pullup (sda_bus);
    assign sda_bus = slv_low ? 1'b0 : 1'bz;

    axis_i2c_byte_master #(.I2C_DATA_WIDTH(8), .AXIS_DATA_WIDTH(16)) dut (
        .clk_i         (clk),
        .arstn_i       (arstn),
        .i2c_scl_o     (scl),
        .i2c_sda_io    (sda_bus),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- slave model ----------------
    // Reacts only to bus edges: START/STOP detection, bit capture on SCL rise,
    // SDA changes on SCL fall. Pulse count includes the SCL rise inside STOP.
    logic        ack_addr = 1'b1;
    logic        ack_wr   = 1'b1;
    logic [7:0]  rd_byte  = 8'h00;
    logic        scl_p, sda_p;
    bit          in_txn;
    int          pulses;
    logic [17:0] cap;
    logic [17:0] rec_cap;
    int          rec_pulses;
    int          stops     = 0;
    int          bad_start = 0;
    bit          mvld_seen = 0;

    initial begin
        slv_low = 1'b0;
        scl_p = 1'b1; sda_p = 1'b1; in_txn = 0; pulses = 0; cap = '0;
        rec_cap = '0; rec_pulses = 0;
    end

    always @(negedge clk) begin
        if (!arstn) begin
            in_txn  = 0;
            slv_low = 1'b0;
            pulses  = 0;
            scl_p   = 1'b1;
            sda_p   = 1'b1;
        end else begin
            if (m_tvalid) mvld_seen = 1;
            if (scl && scl_p && sda_p && !sda_bus) begin
                if (in_txn) bad_start++;
                in_txn = 1; pulses = 0; cap = '0;
            end else if (scl && scl_p && !sda_p && sda_bus) begin
                if (in_txn) begin rec_cap = cap; rec_pulses = pulses; end
                in_txn = 0; stops++; slv_low = 1'b0;
            end else if (in_txn && scl && !scl_p) begin
                if (pulses < 18) cap[pulses] = sda_bus;
                pulses++;
            end else if (in_txn && !scl && scl_p) begin
                slv_low = 1'b0;
                if (pulses == 8)
                    slv_low = ack_addr;
                else if (pulses >= 9 && pulses <= 16 && cap[7] && ack_addr)
                    slv_low = !rd_byte[16 - pulses];
                else if (pulses == 17 && !cap[7])
                    slv_low = ack_wr;
            end
            scl_p = scl;
            sda_p = sda_bus;
        end
    end

    function automatic logic [7:0] cap_byte(input int o);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = rec_cap[o+i];
        return b;
    endfunction

    // ---------------- command driver ----------------
    bit [1:0] tr [0:127];

    function automatic logic [7:0] tr4(input int k);
        return {tr[k], tr[k+1], tr[k+2], tr[k+3]};
    endfunction

    // Issues one command; lat = cycles from handshake until tready returns or read data appears.
    task automatic send(input logic [15:0] w, input bit hold, input logic [15:0] nxt, output int lat);
        int n;
        lat = 0; n = 0;
        s_tdata = w; s_tvalid = 1'b1;
        while (!s_tready && n < 300) begin @(negedge clk); n++; end
        if (!s_tready) begin
            check("accept_timeout", 0, 1);
            s_tvalid = 1'b0; lat = -1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (hold) s_tdata = nxt; else s_tvalid = 1'b0;
        while (lat < 300) begin
            if (lat < 128) tr[lat] = {scl, sda_bus};
            if (s_tready || m_tvalid) break;
            lat++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, hi, s0;
        arstn = 1'b0; s_tdata = 16'h0; s_tvalid = 1'b0; m_tready = 1'b0;
        repeat (3) @(negedge clk);
        s_tvalid = 1'b1;
        #1;
        check("rst_scl",    scl,      1);
        check("rst_sda",    sda_bus,  1);
        check("rst_tready", s_tready, 0);
        check("rst_mvalid", m_tvalid, 0);
        check("rst_mdata",  m_tdata,  8'h00);
        s_tvalid = 1'b0;
        @(negedge clk); arstn = 1'b1;
        repeat (3) @(negedge clk);

        // 1: write 0xA5 to address 0x50, both bytes ACKed
        ack_addr = 1; ack_wr = 1; mvld_seen = 0;
        send(16'hA0A5, 0, 16'h0, lat);
        check("wr_lat",    lat,            80);
        check("wr_start",  tr4(0),         8'hE8);
        check("wr_stop",   tr4(76),        8'h2F);
        check("wr_pulses", rec_pulses,     19);
        check("wr_addr",   cap_byte(0),    8'hA0);
        check("wr_ack1",   rec_cap[8],     0);
        check("wr_data",   cap_byte(9),    8'hA5);
        check("wr_ack2",   rec_cap[17],    0);
        check("wr_no_m",   mvld_seen,      0);

        // 2: read from address 0x50, slave returns 0x3C
        rd_byte = 8'h3C; m_tready = 0;
        send(16'hA100, 0, 16'h0, lat);
        check("rd_lat",    lat,      76);
        check("rd_mvalid", m_tvalid, 1);
        check("rd_mdata",  m_tdata,  8'h3C);

        // 3: read byte stalled with a command pending
        s_tdata = 16'hA05A; s_tvalid = 1'b1; hi = 0;
        repeat (40) begin @(negedge clk); if (s_tready) hi++; end
        check("hold_tready", hi,       0);
        check("hold_mvalid", m_tvalid, 1);
        check("hold_mdata",  m_tdata,  8'h3C);
        check("rd_pulses",   rec_pulses,  19);
        check("rd_addr",     cap_byte(0), 8'hA1);
        check("rd_ack",      rec_cap[8],  0);
        check("rd_bus_data", cap_byte(9), 8'h3C);
        check("rd_mnack",    rec_cap[17], 1);
        m_tready = 1;
        @(negedge clk);
        m_tready = 0;
        check("rd_pop", m_tvalid, 0);
        send(16'hA05A, 0, 16'h0, lat);
        check("pend_lat",  lat,         80);
        check("pend_data", cap_byte(9), 8'h5A);

        // 4: address NACK
        ack_addr = 0; mvld_seen = 0;
        send(16'hA0A5, 0, 16'h0, lat);
        check("nack_lat",    lat,        44);
        check("nack_stop",   tr4(40),    8'h2F);
        check("nack_pulses", rec_pulses, 10);
        check("nack_bit",    rec_cap[8], 1);
        check("nack_no_m",   mvld_seen,  0);
        ack_addr = 1;

        // 5: reset in the middle of the address byte (bit 4 of 0xA0 drives SDA low)
        s_tdata = 16'hA0A5; s_tvalid = 1'b1; hi = 0;
        while (!s_tready && hi < 300) begin @(negedge clk); hi++; end
        @(posedge clk);
        @(negedge clk); s_tvalid = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_rst_bus", {scl, sda_bus}, 2'b00);
        arstn = 1'b0;
        #1;
        check("mid_rst_scl",    scl,      1);
        check("mid_rst_sda",    sda_bus,  1);
        check("mid_rst_mvalid", m_tvalid, 0);
        check("mid_rst_tready", s_tready, 0);
        repeat (2) @(negedge clk);
        arstn = 1'b1;
        send(16'hA0A5, 0, 16'h0, lat);
        check("post_rst_lat",  lat,         80);
        check("post_rst_addr", cap_byte(0), 8'hA0);
        check("post_rst_data", cap_byte(9), 8'hA5);

        // 6: back-to-back writes with tvalid held
        s0 = stops; bad_start = 0;
        send(16'hA011, 1, 16'hA022, lat);
        check("b2b1_lat",  lat,         80);
        check("b2b1_data", cap_byte(9), 8'h11);
        send(16'hA022, 0, 16'h0, lat);
        check("b2b2_lat",  lat,         80);
        check("b2b2_data", cap_byte(9), 8'h22);
        check("b2b_overlap", bad_start, 0);
        check("b2b_stops",   stops - s0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
